// File: rtl/det_event_counter.sv
`default_nettype none
// ============================================================================
//  Module   : det_event_counter
//  Brief    : Consumes the single-cycle detect flag of a serial 11011
//             detector. Keeps a saturating detection count, stretches each
//             detect into a visible LED pulse, and measures the clock
//             distance between consecutive accepted detections.
//  Revision : 1.0  initial release
// ============================================================================
module det_event_counter #(
    parameter int CNT_W   = 8,
    parameter int STRETCH = 4,
    parameter int GAP_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             det_i,
    input  logic             clr_i,
    input  logic             hold_i,
    output logic [CNT_W-1:0] count_o,
    output logic             sat_o,
    output logic             led_o,
    output logic [GAP_W-1:0] gap_o,
    output logic             gap_vld_o
);

    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
    localparam logic [GAP_W-1:0] GAP_MAX      = {GAP_W{1'b1}};
    localparam logic [7:0]       STRETCH_LOAD = 8'(STRETCH - 1);

    typedef enum logic {S_IDLE = 1'b0, S_ON = 1'b1}     led_state_t;
    typedef enum logic {G_NOREF = 1'b0, G_ARMED = 1'b1} gap_state_t;

    // det_i may be a Mealy output upstream: it only ever feeds register inputs.
    logic accept;
    assign accept = det_i & ~clr_i & ~hold_i;

    // ------------------------------------------------------------------------
    // Saturating detection counter with sticky saturation flag
    // ------------------------------------------------------------------------
    // Count accepted detections; stop at the maximum and flag it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_o <= '0;
            sat_o   <= 1'b0;
        end else if (clr_i) begin
            count_o <= '0;
            sat_o   <= 1'b0;
        end else if (accept) begin
            if (count_o < CNT_MAX) begin
                count_o <= count_o + 1'b1;
                if (count_o == CNT_MAX - 1'b1) begin
                    sat_o <= 1'b1;
                end
            end else begin
                sat_o <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // LED pulse stretcher (responds to det_i even while held)
    // ------------------------------------------------------------------------
    led_state_t led_state, led_state_nxt;
    logic [7:0] timer, timer_nxt;

    // Stretcher state and timer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_state <= S_IDLE;
            timer     <= '0;
        end else begin
            led_state <= led_state_nxt;
            timer     <= timer_nxt;
        end
    end

    // Stretcher next state: a new detect reloads rather than accumulates.
    always_comb begin
        led_state_nxt = led_state;
        timer_nxt     = timer;
        if (clr_i) begin
            led_state_nxt = S_IDLE;
            timer_nxt     = '0;
        end else if (det_i) begin
            led_state_nxt = S_ON;
            timer_nxt     = STRETCH_LOAD;
        end else if (led_state == S_ON) begin
            if (timer == 8'd0) begin
                led_state_nxt = S_IDLE;
            end else begin
                timer_nxt = timer - 8'd1;
            end
        end
    end

    assign led_o = (led_state == S_ON);

    // ------------------------------------------------------------------------
    // Inter-detection gap measurement
    // ------------------------------------------------------------------------
    gap_state_t           gap_state, gap_state_nxt;
    logic [GAP_W-1:0]     gap_run, gap_run_nxt;
    logic [GAP_W-1:0]     gap_nxt;
    logic                 gap_vld_nxt;
    logic [GAP_W-1:0]     gap_run_inc;

    // gap_run counts edges since the last accepted detection, so at the
    // next detection gap_run+1 is exactly the edge distance.
    assign gap_run_inc = (gap_run == GAP_MAX) ? GAP_MAX : gap_run + 1'b1;

    // Gap FSM state and measurement registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_state <= G_NOREF;
            gap_run   <= '0;
            gap_o     <= '0;
            gap_vld_o <= 1'b0;
        end else begin
            gap_state <= gap_state_nxt;
            gap_run   <= gap_run_nxt;
            gap_o     <= gap_nxt;
            gap_vld_o <= gap_vld_nxt;
        end
    end

    // Gap FSM next state: first detection only arms, later ones publish.
    always_comb begin
        gap_state_nxt = gap_state;
        gap_run_nxt   = hold_i ? gap_run : gap_run_inc;
        gap_nxt       = gap_o;
        gap_vld_nxt   = gap_vld_o;
        if (clr_i) begin
            gap_state_nxt = G_NOREF;
            gap_run_nxt   = '0;
            gap_nxt       = '0;
            gap_vld_nxt   = 1'b0;
        end else if (accept) begin
            gap_run_nxt = '0;
            case (gap_state)
                G_NOREF: begin
                    gap_state_nxt = G_ARMED;
                end
                G_ARMED: begin
                    gap_nxt     = gap_run_inc;
                    gap_vld_nxt = 1'b1;
                end
                default: begin
                    gap_state_nxt = G_NOREF;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_det_event_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_det_event_counter
//  Brief    : Directed self-checking bench for det_event_counter, with a
//             small non-overlapping 11011 serial detector driving det_i.
//  Revision : 1.0  initial release
// ============================================================================
module tb_det_event_counter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       det_i = 1'b0;
    logic       clr_i = 1'b0;
    logic       hold_i = 1'b0;
    logic [2:0] count_o;
    logic       sat_o;
    logic       led_o;
    logic [7:0] gap_o;
    logic       gap_vld_o;

    int errors = 0;
    int checks = 0;
    logic [3:0] hist = 4'b0;

    det_event_counter #(.CNT_W(3), .STRETCH(4), .GAP_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .det_i     (det_i),
        .clr_i     (clr_i),
        .hold_i    (hold_i),
        .count_o   (count_o),
        .sat_o     (sat_o),
        .led_o     (led_o),
        .gap_o     (gap_o),
        .gap_vld_o (gap_vld_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // One serial bit through a non-overlapping 11011 Mealy detector.
    task automatic send_bit(input logic b);
        logic hit;
        hit   = ({hist, b} == 5'b11011);
        det_i = hit;
        tick();
        hist  = hit ? 4'b0 : {hist[2:0], b};
        det_i = 1'b0;
    endtask

    task automatic send_11011();
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    endtask

    task automatic pulse(input logic h);
        det_i = 1'b1; hold_i = h;
        tick();
        det_i = 1'b0; hold_i = 1'b0;
    endtask

    task automatic do_clear();
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            det_i = i[0];
            tick();
        end
        det_i = 1'b0;
        checks++;
        if ({count_o, sat_o, led_o, gap_o, gap_vld_o} !== 14'd0) begin
            errors++;
            $display("FAIL reset_outputs: got count=%0d sat=%0d led=%0d gap=%0d vld=%0d want all 0",
                     count_o, sat_o, led_o, gap_o, gap_vld_o);
        end
        @(negedge clk) rst_n = 1'b1;
        idle(3);
        checks++;
        if (count_o !== 3'd0 || gap_vld_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got count=%0d vld=%0d want 0 0", count_o, gap_vld_o);
        end
    endtask

    task automatic test_single();
        hist = 4'b0;
        send_11011();
        checks++;
        if (count_o !== 3'd1 || led_o !== 1'b1 || gap_vld_o !== 1'b0) begin
            errors++;
            $display("FAIL single_det: got count=%0d led=%0d vld=%0d want 1 1 0", count_o, led_o, gap_vld_o);
        end
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if (led_o !== (i < 4)) begin
                errors++;
                $display("FAIL single_led_%0d: got %0d want %0d", i, led_o, (i < 4));
            end
        end
    endtask

    task automatic test_back_to_back();
        do_clear();
        hist = 4'b0;
        send_11011();
        send_11011();
        checks++;
        if (count_o !== 3'd2 || gap_o !== 8'd5 || gap_vld_o !== 1'b1 || led_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_gap: got count=%0d gap=%0d vld=%0d led=%0d want 2 5 1 1",
                     count_o, gap_o, gap_vld_o, led_o);
        end
        idle(3);
        checks++;
        if (led_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_led_ext: got %0d want 1", led_o);
        end
        tick();
        checks++;
        if (led_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_led_end: got %0d want 0", led_o);
        end
    endtask

    task automatic test_saturation();
        do_clear();
        for (int i = 1; i <= 9; i++) begin
            pulse(1'b0);
            if (i == 6) begin
                checks++;
                if (count_o !== 3'd6 || sat_o !== 1'b0) begin
                    errors++;
                    $display("FAIL sat_6th: got count=%0d sat=%0d want 6 0", count_o, sat_o);
                end
            end
            if (i == 7) begin
                checks++;
                if (count_o !== 3'd7 || sat_o !== 1'b1) begin
                    errors++;
                    $display("FAIL sat_7th: got count=%0d sat=%0d want 7 1", count_o, sat_o);
                end
            end
            idle(5);
        end
        checks++;
        if (count_o !== 3'd7 || sat_o !== 1'b1) begin
            errors++;
            $display("FAIL sat_9th: got count=%0d sat=%0d want 7 1", count_o, sat_o);
        end
        do_clear();
        checks++;
        if (count_o !== 3'd0 || sat_o !== 1'b0 || gap_vld_o !== 1'b0 || gap_o !== 8'd0) begin
            errors++;
            $display("FAIL sat_clear: got count=%0d sat=%0d vld=%0d gap=%0d want 0 0 0 0",
                     count_o, sat_o, gap_vld_o, gap_o);
        end
    endtask

    task automatic test_hold();
        do_clear();
        pulse(1'b0);
        idle(5);
        pulse(1'b0);
        checks++;
        if (count_o !== 3'd2 || gap_o !== 8'd6 || gap_vld_o !== 1'b1) begin
            errors++;
            $display("FAIL hold_pre: got count=%0d gap=%0d vld=%0d want 2 6 1", count_o, gap_o, gap_vld_o);
        end
        for (int i = 0; i < 3; i++) begin
            idle(2);
            pulse(1'b1);
            checks++;
            if (count_o !== 3'd2 || gap_o !== 8'd6 || led_o !== 1'b1) begin
                errors++;
                $display("FAIL hold_det_%0d: got count=%0d gap=%0d led=%0d want 2 6 1",
                         i, count_o, gap_o, led_o);
            end
        end
        idle(5);
        checks++;
        if (led_o !== 1'b0) begin
            errors++;
            $display("FAIL hold_led_off: got %0d want 0", led_o);
        end
        pulse(1'b0);
        idle(299);
        pulse(1'b0);
        checks++;
        if (gap_o !== 8'd255 || count_o !== 3'd4) begin
            errors++;
            $display("FAIL gap_sat: got gap=%0d count=%0d want 255 4", gap_o, count_o);
        end
    endtask

    task automatic test_clear_priority();
        det_i = 1'b1; clr_i = 1'b1;
        tick();
        det_i = 1'b0; clr_i = 1'b0;
        checks++;
        if (count_o !== 3'd0 || led_o !== 1'b0 || gap_vld_o !== 1'b0 || sat_o !== 1'b0) begin
            errors++;
            $display("FAIL clr_prio: got count=%0d led=%0d vld=%0d sat=%0d want 0 0 0 0",
                     count_o, led_o, gap_vld_o, sat_o);
        end
        pulse(1'b0);
        tick();
        checks++;
        if (count_o !== 3'd1 || led_o !== 1'b1) begin
            errors++;
            $display("FAIL pre_rst: got count=%0d led=%0d want 1 1", count_o, led_o);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (led_o !== 1'b0 || count_o !== 3'd0) begin
            errors++;
            $display("FAIL async_rst: got led=%0d count=%0d want 0 0", led_o, count_o);
        end
        @(negedge clk) rst_n = 1'b1;
        tick();
        pulse(1'b0);
        checks++;
        if (count_o !== 3'd1 || gap_vld_o !== 1'b0) begin
            errors++;
            $display("FAIL post_rst_first: got count=%0d vld=%0d want 1 0", count_o, gap_vld_o);
        end
        idle(4);
        pulse(1'b0);
        checks++;
        if (gap_o !== 8'd5 || gap_vld_o !== 1'b1 || count_o !== 3'd2) begin
            errors++;
            $display("FAIL post_rst_gap: got gap=%0d vld=%0d count=%0d want 5 1 2", gap_o, gap_vld_o, count_o);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_saturation();
        test_hold();
        test_clear_priority();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/det_event_counter.md
Name: det_event_counter

Overview:
- Downstream consumer of the single-cycle detect flag from the serial 11011 sequence detector. The detector drives that flag onto the top-level's first output pin.
- Counts detections with saturation and stretches each detect pulse so it is visible on an LED.
- Measures the clock distance between consecutive detections, giving a readable summary on the dedicated outputs.

Parameters:
- CNT_W, 8, width of the detection counter; saturates at 2^CNT_W-1.
- STRETCH, 4, number of cycles led_o is held high per detection (legal range 1..255).
- GAP_W, 8, width of the gap measurement; saturates at 2^GAP_W-1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- det_i  input  1  detect flag from the sequence detector, sampled on the rising clk edge. It may be combinational (Mealy), so it is never used unregistered.
- clr_i  input  1  synchronous clear of count, saturation, gap and LED state.
- hold_i  input  1  freezes count and gap logic; LED still responds.
- count_o  output  CNT_W  registered detection count.
- sat_o  output  1  sticky flag: the counter reached its maximum.
- led_o  output  1  stretched detect indication.
- gap_o  output  GAP_W  clock edges between the last two accepted detections.
- gap_vld_o  output  1  high once gap_o holds a real measurement.

Behaviour:
- Reset (rst_n low, async): count_o=0, sat_o=0, led_o=0, gap_o=0, gap_vld_o=0, gap_run=0; stretcher FSM to S_IDLE; gap FSM to G_NOREF.
- Priority at each edge: clr_i > hold_i > det_i.
  - clr_i=1 reproduces the reset values at that edge, including led_o=0, regardless of det_i.
- Accepted detection: det_i=1 AND clr_i=0 AND hold_i=0 at an edge.
- Latency: every output reflects a sampled det_i one cycle after the edge (registered outputs); there is no combinational path from det_i to any output.
- Counter:
  - On an accepted detection: count_o <= count_o+1 if count_o < 2^CNT_W-1.
  - Otherwise count_o holds and sat_o <= 1.
  - sat_o also sets on the increment that reaches the maximum value.
  - sat_o is sticky until clr_i or reset; there is no wrap-around.
- Stretcher FSM (states S_IDLE, S_ON; timer width 8):
  - Any det_i=1 with clr_i=0 loads timer=STRETCH-1 and moves to S_ON, whatever hold_i is.
  - In S_ON without a new det: if timer=0, go to S_IDLE; else timer-1.
  - led_o=1 exactly while in S_ON, so an isolated detection gives led_o high for STRETCH consecutive cycles.
  - A det_i arriving during S_ON reloads the timer: the pulse extends, it does not add.
- Gap FSM (states G_NOREF, G_ARMED):
  - gap_run increments every edge, saturating at 2^GAP_W-1, except when hold_i=1, where it holds.
  - G_NOREF: an accepted detection sets gap_run<=0 and moves to G_ARMED; gap_o and gap_vld_o are unchanged.
  - G_ARMED: an accepted detection sets gap_o<=sat(gap_run+1), gap_vld_o<=1, gap_run<=0.
  - Resulting value: detections at accepted edges m and n give gap_o=n-m, saturating.
  - With the non-overlapping 11011 detector upstream, the minimum legal gap is 5. Smaller values are still recorded faithfully.
- Simultaneous events:
  - det_i and hold_i together: LED fires; count and gap are unchanged; gap_run holds.
  - det_i and clr_i together: clear wins and the detection is lost.
- Reset mid-stretch or mid-gap: immediate return to reset values; the next detection after reset is treated as the first one (G_NOREF).

Test Plan:
- Reset state: hold rst_n low, toggle det_i -> all outputs 0. Release reset, no detections -> count_o stays 0 and gap_vld_o stays 0.
- Single detection via serial 11011 into upstream detector: det_i pulses once at edge k -> count_o=1 at k+1, led_o high for cycles k+1..k+4, gap_vld_o=0.
- Back-to-back streams 11011 11011: detections 5 edges apart -> count_o=2, gap_o=5, gap_vld_o=1. The second detection extends led_o to 4 cycles past the second pulse.
- Saturation with CNT_W=3: 9 detections -> count_o=7 after the 7th, sat_o=1, count stays 7. Then clr_i=1 -> count_o=0, sat_o=0, gap_vld_o=0.
- Hold: 3 detections with hold_i=1 -> count_o and gap_o unchanged, led_o still pulses. Gap of 300 edges with GAP_W=8 -> gap_o=255.
- Clear priority and async reset: det_i and clr_i on the same edge -> count_o=0, led_o=0. Assert rst_n low mid-stretch -> led_o drops without waiting for a clock.
